mips_bus_memory_responder: RTL

//  Synthesizable bus-slave memory answering mips_cpu_bus requests (read/write/waitrequest/byteenable).

---
 rtl/mips_bus_memory_responder_pkg.sv | 20 ++
 rtl/mips_bus_memory_responder_if.sv | 20 ++
 rtl/mips_bus_memory_responder_lfsr.sv | 18 +
 rtl/mips_bus_memory_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mips_bus_memory_responder_pkg.sv
// rtl/mips_bus_memory_responder_pkg.sv - Shared constants, FSM states and lane helper for the bus memory responder
package mips_bus_memory_responder_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_t;

  // Expand a 4-bit byte enable into a 32-bit bit mask, lane i -> bits [8i+7:8i].
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mips_bus_memory_responder_if.sv
// rtl/mips_bus_memory_responder_if.sv - CPU data/instruction bus with waitrequest handshake
interface mips_bus_memory_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mips_bus_memory_responder_lfsr.sv
// rtl/mips_bus_memory_responder_lfsr.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) feeding the random stall length
module bus_stall_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= seed;
    end else if (advance) begin
      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
  end

endmodule

// File: rtl/mips_bus_memory_responder.sv
// rtl/mips_bus_memory_responder.sv - Bus-slave memory with data and boot windows and programmable stalls
module mips_bus_memory_responder
  import mips_bus_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 64,
  parameter logic [31:0] DATA_BASE    = 32'h0000_0000,
  parameter logic [31:0] BOOT_BASE    = RESET_VECTOR,
  parameter int unsigned WAIT_CYCLES  = 0,
  parameter bit          RANDOM_STALL = 1'b0,
  parameter int unsigned MAX_EXTRA    = 3,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_bus_memory_responder_if.slave bus,
  output logic                      bad_access
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam int          CNT_W     = (WAIT_CYCLES + MAX_EXTRA > 0) ?
                                      $clog2(WAIT_CYCLES + MAX_EXTRA + 1) : 1;

  logic [31:0] mem [2*DEPTH_WORDS];

  resp_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stall_n;
  logic [7:0]       lfsr_value;
  logic [7:0]       extra;
  logic             req;
  logic             stall;
  logic             complete;

  logic [31:0] data_off;
  logic [31:0] boot_off;
  logic        in_data;
  logic        in_boot;
  logic        access_err;
  logic [IDX_W:0] idx;

  // Unsigned subtraction wraps for addresses below a base, so one compare covers both bounds.
  assign data_off = bus.address - DATA_BASE;
  assign boot_off = bus.address - BOOT_BASE;
  assign in_data  = data_off < WIN_BYTES;
  assign in_boot  = boot_off < WIN_BYTES;
  assign idx      = in_data ? {1'b0, data_off[IDX_W+1:2]} : {1'b1, boot_off[IDX_W+1:2]};

  assign access_err = !(in_data || in_boot) || (bus.address[1:0] != 2'b00) ||
                      (bus.read && bus.write);

  assign req      = bus.read || bus.write;
  assign extra    = RANDOM_STALL ? (lfsr_value & 8'(MAX_EXTRA)) : 8'd0;
  assign stall_n  = CNT_W'(WAIT_CYCLES) + CNT_W'(extra);
  assign complete = req && !stall && !reset;

  // Waitrequest must react to a request in its first cycle, so it is decoded, not registered.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      stall = 1'b1;
    end else if (state == IDLE) begin
      stall = req && (stall_n != '0);
    end else begin
      stall = (cnt != '0);
    end
  end

  assign bus.waitrequest = stall;
  assign bus.readdata    = (bus.read && !access_err) ? mem[idx] : 32'h0;

  bus_stall_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (complete),
    .seed    (LFSR_SEED),
    .value   (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bad_access <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && (stall_n != '0)) begin
            cnt   <= stall_n - 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
      if (complete && access_err) begin
        bad_access <= 1'b1;
      end
    end
  end

  // No reset on the array: contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (complete && bus.write && !access_err) begin
      mem[idx] <= (mem[idx] & ~lane_mask(bus.byteenable)) |
                  (bus.writedata & lane_mask(bus.byteenable));
    end
  end

endmodule
